pipe_hazard_ctrl: RTL

//  Hazard/sequencing controller for the 8-bit pipeline (IF, ID, EX, MEM, WB).
//  - Tracks issued destinations in an internal 3-slot scoreboard (EX, MEM, WB).
//  - Drives the IF/ID and ID/EX register controls: enable, flush and bubble.
//  - Produces registered EX-operand forwarding selects and stalls on load-use.
//  - Flushes on a taken branch and freezes the pipe while data memory is busy.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hz_scoreboard.sv | 85 ++++++++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// controller state encoding, EX operand forwarding select codes and register address width.
package pipe_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hz_scoreboard.sv
// Three-slot destination scoreboard (EX, MEM, WB) shifted with the pipeline, plus the
// ID-source compare that yields load-use detection and registered EX forwarding selects.
module hz_scoreboard
    import pipe_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          shift_en,
    input  logic          load_zero,
    input  logic          id_valid,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic [AW-1:0] id_rd,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    output logic          load_use_o,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o
);

    localparam int NSLOT = 3;
    localparam int NSRC  = 2;

    typedef struct packed {
        logic          regwrite;
        logic          memread;
        logic [AW-1:0] rd;
    } slot_t;

    slot_t                  slot_q [NSLOT];
    slot_t                  slot_d [NSLOT];
    logic [NSRC-1:0][AW-1:0] src_reg;
    logic [NSRC-1:0]        src_use;
    logic [NSRC-1:0]        lu_hit;
    logic [NSRC-1:0][1:0]   fwd_d;
    logic [NSRC-1:0][1:0]   fwd_q;

    assign src_reg = {id_rs2, id_rs1};
    assign src_use = {id_use_rs2, id_use_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi == 0) begin : g_ex
                // A bubble or an invalid ID instruction enters EX as "writes nothing".
                assign slot_d[gi] = load_zero ? '0 : {id_regwrite, id_memread, id_rd};
            end else begin : g_age
                assign slot_d[gi] = slot_q[gi-1];
            end
        end

        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic ex_hit;
            logic mem_hit;
            assign ex_hit  = src_use[gi] && slot_q[0].regwrite && (slot_q[0].rd == src_reg[gi]);
            assign mem_hit = src_use[gi] && slot_q[1].regwrite && (slot_q[1].rd == src_reg[gi]);
            // The EX slot holds the youngest producer, so it takes precedence.
            assign fwd_d[gi]  = ex_hit ? FWD_EXMEM : (mem_hit ? FWD_MEMWB : FWD_RF);
            assign lu_hit[gi] = ex_hit && slot_q[0].memread;
        end
    endgenerate

    always_ff @(posedge clk2) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
            fwd_q <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            fwd_q <= fwd_d;
        end
    end

    assign load_use_o = id_valid && (|lu_hit);
    assign fwd_a_o    = fwd_q[0];
    assign fwd_b_o    = fwd_q[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: RUN/STALL/FLUSH FSM, flush counter, pipeline
// register control decode and a saturating count of hazard cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = pipe_pkg::REG_AW,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              stage_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  hz_cnt
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] hz_q, hz_d;
    logic             load_use;

    hz_scoreboard #(
        .AW (REG_AW)
    ) u_sb (
        .clk2        (clk2),
        .rst         (rst),
        .shift_en    (stage_en),
        .load_zero   (idex_bubble | ~id_valid),
        .id_valid    (id_valid),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .load_use_o  (load_use),
        .fwd_a_o     (fwd_a),
        .fwd_b_o     (fwd_b)
    );

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        hz_d        = hz_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        stage_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            stage_en = 1'b0;
        end else begin
            if ((state_q != ST_RUN) && (hz_q != '1)) begin
                hz_d = hz_q + CNT_W'(1);
            end
            if (br_taken && (state_q != ST_FLUSH)) begin
                // The branch cycle itself squashes; FLUSH covers the remaining wrong-path slots.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                fcnt_d      = FLUSH_INIT;
                state_d     = (FLUSH_INIT != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                fcnt_d      = fcnt_q - 2'd1;
                if (fcnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end else if ((state_q == ST_RUN) && load_use) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                state_d     = ST_STALL;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
            hz_q    <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            hz_q    <= hz_d;
        end
    end

    assign state_o = state_q;
    assign hz_cnt  = hz_q;

endmodule
